// File: rtl/clk_set_pkg.sv
// clk_set_pkg: state encoding, digit indices and helpers shared by the
// timekeeper set front-end.
package clk_set_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_DB,
      ST_HELD,
      ST_REPEAT,
      ST_RELEASE_DB
   } btn_state_e;

   localparam int NUM_DIGITS = 6;
   localparam int IDX_SEC1   = 0;
   localparam int IDX_SEC10  = 1;
   localparam int IDX_MIN1   = 2;
   localparam int IDX_MIN10  = 3;
   localparam int IDX_HOUR1  = 4;
   localparam int IDX_HOUR10 = 5;

   localparam int PRIO_ORDER [NUM_DIGITS] = '{
      IDX_HOUR10, IDX_HOUR1, IDX_MIN10,
      IDX_MIN1, IDX_SEC10, IDX_SEC1
   };

   function automatic int cnt_width(
      input int a,
      input int b,
      input int c,
      input int d
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m + 1);
   endfunction

   function automatic logic [NUM_DIGITS-1:0] prio_grant(
      input logic [NUM_DIGITS-1:0] req
   );
      logic [NUM_DIGITS-1:0] g;
      logic                  found;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!found && req[PRIO_ORDER[i]]) begin
            g[PRIO_ORDER[i]] = 1'b1;
            found            = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/clk_set_ctrl_btn_conditioner.sv
// btn_conditioner: 2-FF sync, debounce FSM and a one-cycle press event.
// Repeat logic is built only when CLK_SET_AUTO_REPEAT_EN is defined.
module btn_conditioner
   import clk_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
`ifdef CLK_SET_AUTO_REPEAT_EN
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 5,
   parameter bit REPEAT_EN     = 1'b1,
`endif
   parameter int CW = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic fire
);

   logic [1:0]    sync_q;
   logic          in_q;
   logic          level;
   logic          rise;
   btn_state_e    state;
   btn_state_e    state_d;
   logic          from_rep;
   logic          from_rep_d;
   logic [CW-1:0] db_cnt;
   logic [CW-1:0] db_cnt_d;
   logic [CW-1:0] db_inc;
   logic          db_done;
   logic          fire_d;
   logic          rep_hit;

   assign level   = sync_q[1];
   assign rise    = level & ~in_q;
   assign db_inc  = db_cnt + 1'b1;
   assign db_done = db_inc >= CW'(DEBOUNCE_CYCLES);

   // Chain resets high: a button held through reset is not a fresh rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
         in_q   <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], raw};
         in_q   <= level;
      end
   end

`ifdef CLK_SET_AUTO_REPEAT_EN
   logic [CW-1:0] rep_cnt;
   logic [CW-1:0] rep_cnt_d;
   logic [CW-1:0] rep_inc;

   assign rep_inc = rep_cnt + 1'b1;
   assign rep_hit = REPEAT_EN && level &&
                    ((state == ST_HELD) ?
                     (rep_inc >= CW'(REPEAT_DELAY)) :
                     (rep_inc >= CW'(REPEAT_PERIOD)));

   always_comb begin
      rep_cnt_d = rep_cnt;
      unique case (state)
         ST_HELD, ST_REPEAT: begin
            if (level) rep_cnt_d = rep_hit ? '0 : rep_inc;
         end
         ST_RELEASE_DB: rep_cnt_d = rep_cnt;
         default:       rep_cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rep_cnt <= '0;
      else       rep_cnt <= rep_cnt_d;
   end
`else
   assign rep_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state;
      db_cnt_d   = db_cnt;
      from_rep_d = from_rep;
      fire_d     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            db_cnt_d = '0;
            if (rise) begin
               if (db_done) begin
                  state_d = ST_HELD;
                  fire_d  = 1'b1;
               end else begin
                  state_d  = ST_PRESS_DB;
                  db_cnt_d = db_inc;
               end
            end
         end
         ST_PRESS_DB: begin
            if (!level) begin
               state_d  = ST_IDLE;
               db_cnt_d = '0;
            end else if (db_done) begin
               state_d  = ST_HELD;
               db_cnt_d = '0;
               fire_d   = 1'b1;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         ST_HELD, ST_REPEAT: begin
            if (!level) begin
               state_d    = ST_RELEASE_DB;
               from_rep_d = (state == ST_REPEAT);
               db_cnt_d   = db_inc;
            end else if (rep_hit) begin
               state_d = ST_REPEAT;
               fire_d  = 1'b1;
            end
         end
         ST_RELEASE_DB: begin
            if (level) begin
               state_d  = from_rep ? ST_REPEAT : ST_HELD;
               db_cnt_d = '0;
            end else if (db_done) begin
               state_d  = ST_IDLE;
               db_cnt_d = '0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         db_cnt   <= '0;
         from_rep <= 1'b0;
         fire     <= 1'b0;
      end else begin
         state    <= state_d;
         db_cnt   <= db_cnt_d;
         from_rep <= from_rep_d;
         fire     <= fire_d;
      end
   end

endmodule

// File: rtl/clk_set_ctrl.sv
// clk_set_ctrl: push-button front-end for the 12-hour timekeeper set inputs.
// Define CLK_SET_AUTO_REPEAT_EN to add auto-repeat on held digit buttons.
module clk_set_ctrl
   import clk_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 20,
   parameter int REPEAT_PERIOD   = 5,
   parameter int TIMEOUT_CYCLES  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode_raw,
   input  logic [5:0] btn_raw,
   output logic       set_time,
   output logic       hour10,
   output logic       hour1,
   output logic       min10,
   output logic       min1,
   output logic       sec10,
   output logic       sec1,
   output logic       busy
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                 REPEAT_PERIOD, TIMEOUT_CYCLES);

   logic                  mode_fire;
   logic [NUM_DIGITS-1:0] dig_fire;
   logic [NUM_DIGITS-1:0] req;
   logic [NUM_DIGITS-1:0] grant;
   logic [NUM_DIGITS-1:0] pending;
   logic [NUM_DIGITS-1:0] pending_d;
   logic [NUM_DIGITS-1:0] pulse_q;
   logic [NUM_DIGITS-1:0] pulse_d;
   logic [CW-1:0]         idle_cnt;
   logic [CW-1:0]         idle_d;
   logic [CW-1:0]         idle_inc;
   logic                  any_fire;
   logic                  timeout;
   logic                  clear;
   logic                  set_d;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef CLK_SET_AUTO_REPEAT_EN
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (1'b0),
`endif
      .CW             (CW)
   ) u_mode (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_mode_raw),
      .fire (mode_fire)
   );

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      btn_conditioner #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef CLK_SET_AUTO_REPEAT_EN
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .REPEAT_EN      (1'b1),
`endif
         .CW             (CW)
      ) u_btn (
         .clk  (clk),
         .reset(reset),
         .raw  (btn_raw[i]),
         .fire (dig_fire[i])
      );
   end

   // Digit events outside set mode are dropped; leaving set mode flushes.
   always_comb begin
      any_fire = mode_fire | (|dig_fire);
      idle_inc = idle_cnt + 1'b1;
      timeout  = set_time && !any_fire &&
                 (idle_inc >= CW'(TIMEOUT_CYCLES));
      clear    = (mode_fire && set_time) || timeout;
      req      = pending | (set_time ? dig_fire : '0);
      grant    = prio_grant(req);

      set_d     = clear ? 1'b0 : (set_time | mode_fire);
      pending_d = clear ? '0 : (req & ~grant);
      pulse_d   = clear ? '0 : grant;

      if (!set_time || any_fire || timeout) idle_d = '0;
      else                                  idle_d = idle_inc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         set_time <= 1'b0;
         pending  <= '0;
         pulse_q  <= '0;
         idle_cnt <= '0;
      end else begin
         set_time <= set_d;
         pending  <= pending_d;
         pulse_q  <= pulse_d;
         idle_cnt <= idle_d;
      end
   end

   assign hour10 = pulse_q[IDX_HOUR10];
   assign hour1  = pulse_q[IDX_HOUR1];
   assign min10  = pulse_q[IDX_MIN10];
   assign min1   = pulse_q[IDX_MIN1];
   assign sec10  = pulse_q[IDX_SEC10];
   assign sec1   = pulse_q[IDX_SEC1];
   assign busy   = |pending;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// tb_clk_set_ctrl: table-driven vectors plus hand sequences for timeout,
// auto-repeat (CLK_SET_AUTO_REPEAT_EN) and reset while a button is held.
module tb_clk_set_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode_raw;
   logic [5:0] btn_raw;
   logic       set_time;
   logic       hour10;
   logic       hour1;
   logic       min10;
   logic       min1;
   logic       sec10;
   logic       sec1;
   logic       busy;
   logic [5:0] dig;

   int checks = 0;
   int errors = 0;
   int pcnt [6];
   int base [6];

   typedef struct packed {
      logic       mode;
      logic [5:0] btn;
      logic [7:0] wait_n;
      logic       set_exp;
      logic [5:0] dig_exp;
      logic       busy_exp;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   assign dig = {hour10, hour1, min10, min1, sec10, sec1};

   always #5 clk = ~clk;

   clk_set_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .btn_mode_raw(btn_mode_raw),
      .btn_raw     (btn_raw),
      .set_time    (set_time),
      .hour10      (hour10),
      .hour1       (hour1),
      .min10       (min10),
      .min1        (min1),
      .sec10       (sec10),
      .sec1        (sec1),
      .busy        (busy)
   );

   always @(negedge clk) begin
      for (int i = 0; i < 6; i++) pcnt[i] <= pcnt[i] + int'(dig[i]);
   end

   function automatic vec_t mk(input logic m, input logic [5:0] b,
                               input int w, input logic s,
                               input logic [5:0] d, input logic bz);
      vec_t r;
      r.mode     = m;
      r.btn      = b;
      r.wait_n   = w[7:0];
      r.set_exp  = s;
      r.dig_exp  = d;
      r.busy_exp = bz;
      return r;
   endfunction

   function automatic logic rep_exp(input int off);
`ifdef CLK_SET_AUTO_REPEAT_EN
      return (off == 0) ||
             (off >= 20 && off <= 45 && (off % 5) == 0);
`else
      return (off == 0);
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m, input logic [5:0] b);
      btn_mode_raw = m;
      btn_raw      = b;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 6; i++) base[i] = pcnt[i];
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: no finish within 1000000 ns");
      $fatal(1);
   end

   initial begin
      logic [5:0] exp_cnt;

      reset = 1'b1;
      drive(1'b0, 6'b0);
      step(3);
      chk("reset_outs", 32'({set_time, dig, busy}), 32'd0);
      reset = 1'b0;
      snap();

      vecs[0]  = mk(0, 6'b000000, 4, 0, 6'b000000, 0);
      vecs[1]  = mk(1, 6'b000000, 6, 0, 6'b000000, 0);
      vecs[2]  = mk(1, 6'b000000, 1, 1, 6'b000000, 0);
      vecs[3]  = mk(1, 6'b000000, 3, 1, 6'b000000, 0);
      vecs[4]  = mk(0, 6'b000000, 10, 1, 6'b000000, 0);
      vecs[5]  = mk(0, 6'b000100, 3, 1, 6'b000000, 0);
      vecs[6]  = mk(0, 6'b000000, 4, 1, 6'b000000, 0);
      vecs[7]  = mk(0, 6'b000000, 6, 1, 6'b000000, 0);
      vecs[8]  = mk(0, 6'b000100, 4, 1, 6'b000000, 0);
      vecs[9]  = mk(0, 6'b000000, 2, 1, 6'b000000, 0);
      vecs[10] = mk(0, 6'b000000, 1, 1, 6'b000100, 0);
      vecs[11] = mk(0, 6'b000000, 1, 1, 6'b000000, 0);
      vecs[12] = mk(0, 6'b110000, 6, 1, 6'b000000, 0);
      vecs[13] = mk(0, 6'b110000, 1, 1, 6'b100000, 1);
      vecs[14] = mk(0, 6'b110000, 1, 1, 6'b010000, 0);
      vecs[15] = mk(0, 6'b110000, 1, 1, 6'b000000, 0);
      vecs[16] = mk(0, 6'b000000, 8, 1, 6'b000000, 0);
      vecs[17] = mk(1, 6'b000000, 6, 1, 6'b000000, 0);
      vecs[18] = mk(1, 6'b000000, 1, 0, 6'b000000, 0);
      vecs[19] = mk(0, 6'b000000, 8, 0, 6'b000000, 0);
      vecs[20] = mk(0, 6'b001000, 7, 0, 6'b000000, 0);
      vecs[21] = mk(0, 6'b000000, 1, 0, 6'b000000, 0);
      vecs[22] = mk(0, 6'b000000, 8, 0, 6'b000000, 0);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].mode, vecs[i].btn);
         step(int'(vecs[i].wait_n));
         chk($sformatf("vec%0d {set,dig,busy}", i),
             32'({set_time, dig, busy}),
             32'({vecs[i].set_exp, vecs[i].dig_exp, vecs[i].busy_exp}));
      end

      exp_cnt = 6'b110100;
      for (int i = 0; i < 6; i++)
         chk($sformatf("table_pulses_bit%0d", i),
             32'(pcnt[i] - base[i]), 32'(exp_cnt[i]));

      // Timeout with no presses.
      drive(1'b1, 6'b0);
      step(7);
      chk("to_enter", 32'(set_time), 32'd1);
      step(3);
      drive(1'b0, 6'b0);
      step(96);
      chk("to_last_cycle", 32'(set_time), 32'd1);
      step(1);
      chk("to_exit", 32'(set_time), 32'd0);

      // A sec1 press at idle cycle 90 restarts the count.
      drive(1'b1, 6'b0);
      step(7);
      chk("tr_enter", 32'(set_time), 32'd1);
      step(3);
      drive(1'b0, 6'b0);
      step(80);
      drive(1'b0, 6'b000001);
      step(5);
      drive(1'b0, 6'b0);
      step(1);
      chk("tr_sec1_pre", 32'(sec1), 32'd0);
      step(1);
      chk("tr_sec1", 32'(sec1), 32'd1);
      step(10);
      chk("tr_past_100", 32'(set_time), 32'd1);
      step(89);
      chk("tr_189", 32'(set_time), 32'd1);
      step(1);
      chk("tr_190", 32'(set_time), 32'd0);

      // Hold sec10; pulse offsets depend on auto-repeat.
      drive(1'b1, 6'b0);
      step(7);
      chk("rp_enter", 32'(set_time), 32'd1);
      step(3);
      drive(1'b0, 6'b0);
      step(10);
      drive(1'b0, 6'b000010);
      for (int k = 1; k <= 70; k++) begin
         step(1);
         chk($sformatf("rp_sec10_k%0d", k),
             32'(sec10), 32'(rep_exp(k - 7)));
         if (k == 50) drive(1'b0, 6'b0);
      end

      // Reset with pending nonzero and hour1 held.
      drive(1'b0, 6'b110000);
      step(7);
      chk("rh_busy_pre", 32'(busy), 32'd1);
      chk("rh_hour10_pre", 32'(hour10), 32'd1);
      drive(1'b0, 6'b010000);
      #2;
      reset = 1'b1;
      #1;
      chk("rh_outs_in_reset", 32'({set_time, dig, busy}), 32'd0);
      step(3);
      reset = 1'b0;
      snap();
      step(4);
      drive(1'b1, 6'b010000);
      step(7);
      chk("rh_enter", 32'(set_time), 32'd1);
      step(3);
      drive(1'b0, 6'b010000);
      step(20);
      chk("rh_held_no_pulse", 32'(pcnt[4] - base[4]), 32'd0);
      chk("rh_busy_idle", 32'(busy), 32'd0);
      drive(1'b0, 6'b0);
      step(10);
      drive(1'b0, 6'b010000);
      step(6);
      chk("rh_repress_pre", 32'(hour1), 32'd0);
      step(1);
      chk("rh_repress", 32'(hour1), 32'd1);
      step(1);
      drive(1'b0, 6'b0);
      step(10);
      chk("rh_total_hour1", 32'(pcnt[4] - base[4]), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
